// File: rtl/pipe_ctrl_gen_if.sv
// Pipeline-control bus: stall/hazard requests in, per-stage hold and per-boundary bubble out.
interface pipe_ctrl_gen_if #(
  parameter int NSTAGE = 5,
  parameter int NREQ   = 4,
  parameter int CNT_W  = 16
);
  logic [NREQ-1:0]   stall_req_i;
  logic              redirect_i;
  logic              fence_req_i;
  logic              mem_busy_i;
  logic              wfi_req_i;
  logic              pipe_busy_i;
  logic              wake_i;
  logic              cnt_clr_i;
  logic [NSTAGE-1:0] stall_o;
  logic [NSTAGE-2:0] flush_o;
  logic              fence_done_o;
  logic              sleeping_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output stall_req_i, redirect_i, fence_req_i, mem_busy_i,
    output wfi_req_i, pipe_busy_i, wake_i, cnt_clr_i,
    input  stall_o, flush_o, fence_done_o, sleeping_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  stall_req_i, redirect_i, fence_req_i, mem_busy_i,
    input  wfi_req_i, pipe_busy_i, wake_i, cnt_clr_i,
    output stall_o, flush_o, fence_done_o, sleeping_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_gen.sv
// Parametrised in-order pipeline controller: prioritised stall arbitration, fence/WFI
// sequencing FSM, deferred redirect flush and saturating performance counters.
module pipe_ctrl_gen #(
  parameter int                     NSTAGE      = 5,
  parameter int                     NREQ        = 4,
  parameter logic [NREQ*NSTAGE-1:0] REQ_MASK    = {5'b00111, 5'b00011, 5'b00111, 5'b00001},
  parameter int                     REDIR_DEPTH = 2,
  parameter int                     CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  pipe_ctrl_gen_if.slave bus
);

  typedef enum logic [2:0] {RUN, FENCE, WFI_DRAIN, WFI_SLEEP, WAKE} state_e;

  state_e            state_q, state_d;
  logic              redirPend_q, redirPend_d;
  logic              wakePend_q, wakePend_d;
  logic [CNT_W-1:0]  stallCnt_q, flushCnt_q;

  logic [NSTAGE-1:0] arbMask, fsmMask, stallAll;
  logic [NSTAGE-2:0] arbFlush, fsmFlush, redirFlush, flushAll;
  logic              arbFound, fenceDone, sleeping, redirActive;

  always_comb begin
    arbMask  = '0;
    arbFlush = '0;
    arbFound = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!arbFound && bus.stall_req_i[i]) begin
        arbFound = 1'b1;
        arbMask  = REQ_MASK[i*NSTAGE +: NSTAGE];
      end
    end
    // Masks are contiguous from bit 0, so the top set bit is where a 1 meets a 0 above it.
    for (int b = 0; b < NSTAGE-1; b++) begin
      if (arbMask[b] && !arbMask[b+1]) arbFlush[b] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wakePend_d = wakePend_q;
    fsmMask    = '0;
    fsmFlush   = '0;
    fenceDone  = 1'b0;
    sleeping   = 1'b0;
    case (state_q)
      RUN: begin
        wakePend_d = 1'b0;
        if (bus.wfi_req_i) begin
          state_d = WFI_DRAIN;
        end else if (bus.fence_req_i) begin
          if (bus.mem_busy_i) state_d = FENCE;
          else                fenceDone = 1'b1;
        end
      end
      FENCE: begin
        fsmMask     = {{(NSTAGE-2){1'b0}}, 2'b11};
        fsmFlush[1] = 1'b1;
        if (!bus.mem_busy_i) begin
          fenceDone = 1'b1;
          state_d   = RUN;
        end
      end
      WFI_DRAIN: begin
        fsmMask     = {{(NSTAGE-2){1'b0}}, 2'b11};
        fsmFlush[1] = 1'b1;
        // A wake seen while draining is remembered so sleep is left immediately.
        if (bus.wake_i)       wakePend_d = 1'b1;
        if (!bus.pipe_busy_i) state_d    = WFI_SLEEP;
      end
      WFI_SLEEP: begin
        fsmMask  = '1;
        sleeping = 1'b1;
        if (bus.wake_i || wakePend_q) begin
          state_d    = WAKE;
          wakePend_d = 1'b0;
        end
      end
      WAKE: begin
        fsmFlush[0] = 1'b1;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
    if (bus.redirect_i && (state_q == FENCE || state_q == WFI_DRAIN || state_q == WFI_SLEEP)) begin
      state_d    = RUN;
      wakePend_d = 1'b0;
    end
  end

  // Redirect flushes fully only when fetch moves; otherwise boundary 0 waits in redirPend.
  always_comb begin
    stallAll    = fsmMask | arbMask;
    redirActive = bus.redirect_i | redirPend_q;
    redirFlush  = '0;
    for (int b = 0; b < NSTAGE-1; b++) begin
      if (b < REDIR_DEPTH) begin
        if (redirActive && !stallAll[0])
          redirFlush[b] = 1'b1;
        else if (bus.redirect_i && stallAll[0] && (b > 0) && !stallAll[b+1])
          redirFlush[b] = 1'b1;
      end
    end
    redirPend_d = stallAll[0] ? redirActive : 1'b0;
    flushAll    = (stallAll[NSTAGE-2:0] & ~stallAll[NSTAGE-1:1])
                | ((fsmFlush | arbFlush) & ~stallAll[NSTAGE-1:1])
                | redirFlush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      redirPend_q <= 1'b0;
      wakePend_q  <= 1'b0;
      stallCnt_q  <= '0;
      flushCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      redirPend_q <= redirPend_d;
      wakePend_q  <= wakePend_d;
      if (bus.cnt_clr_i) begin
        stallCnt_q <= '0;
        flushCnt_q <= '0;
      end else begin
        if (stallAll[0] && (stallCnt_q != '1))
          stallCnt_q <= stallCnt_q + CNT_W'(1);
        if (redirActive && !stallAll[0] && (flushCnt_q != '1))
          flushCnt_q <= flushCnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.stall_o      = rst ? '0 : stallAll;
  assign bus.flush_o      = rst ? '0 : flushAll;
  assign bus.fence_done_o = ~rst & fenceDone;
  assign bus.sleeping_o   = ~rst & sleeping;
  assign bus.stall_cnt_o  = stallCnt_q;
  assign bus.flush_cnt_o  = flushCnt_q;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Self-checking bench for pipe_ctrl_gen; a second instance with 4-bit counters
// shares the same stimulus so saturation is reachable in a few cycles.
module tb_pipe_ctrl_gen;

  // Stimulus word = {stall_req[3:0], redirect, fence, mem_busy, wfi, pipe_busy, wake, cnt_clr}
  localparam logic [6:0] IDLE  = 7'b0000000;
  localparam logic [6:0] REDIR = 7'b1000000;
  localparam logic [6:0] FENCE = 7'b0100000;
  localparam logic [6:0] MBUSY = 7'b0010000;
  localparam logic [6:0] WFI   = 7'b0001000;
  localparam logic [6:0] PBUSY = 7'b0000100;
  localparam logic [6:0] WAKE  = 7'b0000010;
  localparam logic [6:0] CLR   = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  // Expected observation = {stall_o[4:0], flush_o[3:0], fence_done_o, sleeping_o}
  logic [10:0] expQ[$];

  always #5 clk = ~clk;

  pipe_ctrl_gen_if #(.NSTAGE(5), .NREQ(4), .CNT_W(16)) bus16();
  pipe_ctrl_gen_if #(.NSTAGE(5), .NREQ(4), .CNT_W(4))  bus4();

  pipe_ctrl_gen #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus16.slave));
  pipe_ctrl_gen #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  assign bus4.stall_req_i = bus16.stall_req_i;
  assign bus4.redirect_i  = bus16.redirect_i;
  assign bus4.fence_req_i = bus16.fence_req_i;
  assign bus4.mem_busy_i  = bus16.mem_busy_i;
  assign bus4.wfi_req_i   = bus16.wfi_req_i;
  assign bus4.pipe_busy_i = bus16.pipe_busy_i;
  assign bus4.wake_i      = bus16.wake_i;
  assign bus4.cnt_clr_i   = bus16.cnt_clr_i;

  task automatic drive(input logic [10:0] s);
    {bus16.stall_req_i, bus16.redirect_i, bus16.fence_req_i, bus16.mem_busy_i,
     bus16.wfi_req_i, bus16.pipe_busy_i, bus16.wake_i, bus16.cnt_clr_i} = s;
  endtask

  function automatic logic [10:0] observe();
    return {bus16.stall_o, bus16.flush_o, bus16.fence_done_o, bus16.sleeping_o};
  endfunction

  task automatic test_reset();
    logic [10:0] got, ex;
    drive({4'b1111, REDIR | FENCE | MBUSY | WFI});
    expQ.push_back(11'd0);
    @(negedge clk);
    got = observe();
    ex  = expQ.pop_front();
    checks++;
    if (got !== ex) $display("[TB] FAIL reset_outputs got %b expected %b", got, ex);
    else passes++;
    checks++;
    if (bus16.stall_cnt_o !== 16'd0) $display("[TB] FAIL reset_stall_cnt got %0d expected 0", bus16.stall_cnt_o);
    else passes++;
    checks++;
    if (bus16.flush_cnt_o !== 16'd0) $display("[TB] FAIL reset_flush_cnt got %0d expected 0", bus16.flush_cnt_o);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    drive({4'b0000, IDLE});
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    logic [10:0] stim [6];
    logic [10:0] exps [6];
    logic [10:0] got, ex;
    stim = '{{4'b0101, IDLE}, {4'b0100, IDLE}, {4'b0010, IDLE},
             {4'b1000, IDLE}, {4'b1100, IDLE}, {4'b0000, IDLE}};
    exps = '{{5'b00001, 4'b0001, 2'b00}, {5'b00011, 4'b0010, 2'b00},
             {5'b00111, 4'b0100, 2'b00}, {5'b00111, 4'b0100, 2'b00},
             {5'b00011, 4'b0010, 2'b00}, 11'd0};
    for (int i = 0; i < 6; i++) begin
      drive(stim[i]);
      expQ.push_back(exps[i]);
      @(negedge clk);
      got = observe();
      ex  = expQ.pop_front();
      checks++;
      if (got !== ex) $display("[TB] FAIL arb[%0d] got %b expected %b", i, got, ex);
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fence();
    logic [10:0] stim [10];
    logic [10:0] exps [10];
    logic [10:0] got, ex;
    stim = '{{4'b0000, FENCE | MBUSY}, {4'b0000, FENCE | MBUSY}, {4'b0010, FENCE | MBUSY},
             {4'b0000, FENCE},         {4'b0000, IDLE},          {4'b0000, FENCE},
             {4'b0000, WFI | FENCE},   {4'b0000, REDIR},         {4'b0000, IDLE},
             {4'b0000, IDLE}};
    exps = '{11'd0,
             {5'b00011, 4'b0010, 2'b00},
             {5'b00111, 4'b0100, 2'b00},
             {5'b00011, 4'b0010, 2'b10},
             11'd0,
             {5'b00000, 4'b0000, 2'b10},
             11'd0,
             {5'b00011, 4'b0010, 2'b00},
             {5'b00000, 4'b0011, 2'b00},
             11'd0};
    for (int i = 0; i < 10; i++) begin
      drive(stim[i]);
      expQ.push_back(exps[i]);
      @(negedge clk);
      got = observe();
      ex  = expQ.pop_front();
      checks++;
      if (got !== ex) $display("[TB] FAIL fence[%0d] got %b expected %b", i, got, ex);
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wfi();
    logic [10:0] stim [15];
    logic [10:0] exps [15];
    logic [10:0] got, ex;
    stim = '{{4'b0, WFI | PBUSY}, {4'b0, PBUSY}, {4'b0, IDLE}, {4'b0, IDLE}, {4'b0, IDLE},
             {4'b0, IDLE}, {4'b0, WAKE}, {4'b0, IDLE}, {4'b0, IDLE},
             {4'b0, WFI | PBUSY}, {4'b0, PBUSY | WAKE}, {4'b0, IDLE}, {4'b0, IDLE},
             {4'b0, IDLE}, {4'b0, IDLE}};
    exps = '{11'd0,
             {5'b00011, 4'b0010, 2'b00}, {5'b00011, 4'b0010, 2'b00},
             {5'b11111, 4'b0000, 2'b01}, {5'b11111, 4'b0000, 2'b01},
             {5'b11111, 4'b0000, 2'b01}, {5'b11111, 4'b0000, 2'b01},
             {5'b00000, 4'b0001, 2'b00}, 11'd0,
             11'd0,
             {5'b00011, 4'b0010, 2'b00}, {5'b00011, 4'b0010, 2'b00},
             {5'b11111, 4'b0000, 2'b01},
             {5'b00000, 4'b0001, 2'b00}, 11'd0};
    for (int i = 0; i < 15; i++) begin
      drive(stim[i]);
      expQ.push_back(exps[i]);
      @(negedge clk);
      got = observe();
      ex  = expQ.pop_front();
      checks++;
      if (got !== ex) $display("[TB] FAIL wfi[%0d] got %b expected %b", i, got, ex);
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    logic [10:0] stim [19];
    logic [10:0] exps [19];
    logic [15:0] cntExp [19];
    logic [10:0] got, ex;
    drive({4'b0, CLR});
    @(posedge clk); #1;
    stim = '{{4'b0000, REDIR}, {4'b0000, IDLE},
             {4'b0100, REDIR}, {4'b0100, IDLE}, {4'b0100, REDIR}, {4'b0100, IDLE},
             {4'b0000, IDLE},  {4'b0000, IDLE},
             {4'b0000, WFI},   {4'b0000, IDLE}, {4'b0000, REDIR}, {4'b0000, IDLE},
             {4'b0000, REDIR}, {4'b0000, REDIR}, {4'b0000, IDLE},
             {4'b0000, FENCE | MBUSY}, {4'b0000, FENCE | MBUSY | REDIR},
             {4'b0000, IDLE},  {4'b0000, IDLE}};
    exps = '{{5'b00000, 4'b0011, 2'b00}, 11'd0,
             {5'b00011, 4'b0010, 2'b00}, {5'b00011, 4'b0010, 2'b00},
             {5'b00011, 4'b0010, 2'b00}, {5'b00011, 4'b0010, 2'b00},
             {5'b00000, 4'b0011, 2'b00}, 11'd0,
             11'd0, {5'b00011, 4'b0010, 2'b00}, {5'b11111, 4'b0000, 2'b01},
             {5'b00000, 4'b0011, 2'b00},
             {5'b00000, 4'b0011, 2'b00}, {5'b00000, 4'b0011, 2'b00}, 11'd0,
             11'd0, {5'b00011, 4'b0010, 2'b00},
             {5'b00000, 4'b0011, 2'b00}, 11'd0};
    cntExp = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2,
               16'd2, 16'd2, 16'd3, 16'd4, 16'd5, 16'd5, 16'd5, 16'd5, 16'd6};
    for (int i = 0; i < 19; i++) begin
      drive(stim[i]);
      expQ.push_back(exps[i]);
      @(negedge clk);
      got = observe();
      ex  = expQ.pop_front();
      checks++;
      if (got !== ex) $display("[TB] FAIL redir[%0d] got %b expected %b", i, got, ex);
      else passes++;
      checks++;
      if (bus16.flush_cnt_o !== cntExp[i])
        $display("[TB] FAIL redir_cnt[%0d] got %0d expected %0d", i, bus16.flush_cnt_o, cntExp[i]);
      else passes++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_counters();
    drive({4'b0000, CLR});
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      drive({4'b0001, IDLE});
      @(posedge clk); #1;
    end
    drive({4'b0000, IDLE});
    @(negedge clk);
    checks++;
    if (bus4.stall_cnt_o !== 4'hF) $display("[TB] FAIL sat_cnt4 got %h expected f", bus4.stall_cnt_o);
    else passes++;
    checks++;
    if (bus16.stall_cnt_o !== 16'd20) $display("[TB] FAIL cnt16 got %0d expected 20", bus16.stall_cnt_o);
    else passes++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus4.stall_cnt_o !== 4'hF) $display("[TB] FAIL sat_hold got %h expected f", bus4.stall_cnt_o);
    else passes++;
    @(posedge clk); #1;
    drive({4'b0001, CLR});
    @(negedge clk);
    checks++;
    if (bus4.stall_cnt_o !== 4'hF) $display("[TB] FAIL clr_same_cycle got %h expected f", bus4.stall_cnt_o);
    else passes++;
    @(posedge clk); #1;
    drive({4'b0000, IDLE});
    @(negedge clk);
    checks++;
    if (bus4.stall_cnt_o !== 4'h0) $display("[TB] FAIL clr_cnt4 got %h expected 0", bus4.stall_cnt_o);
    else passes++;
    checks++;
    if (bus16.stall_cnt_o !== 16'd0) $display("[TB] FAIL clr_cnt16 got %0d expected 0", bus16.stall_cnt_o);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [10:0] got, ex;
    drive({4'b0000, WFI});
    @(posedge clk); #1;
    drive({4'b0000, IDLE});
    @(posedge clk); #1;
    expQ.push_back({5'b11111, 4'b0000, 2'b01});
    @(negedge clk);
    got = observe();
    ex  = expQ.pop_front();
    checks++;
    if (got !== ex) $display("[TB] FAIL mid_sleep got %b expected %b", got, ex);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
    expQ.push_back(11'd0);
    #1;
    got = observe();
    ex  = expQ.pop_front();
    checks++;
    if (got !== ex) $display("[TB] FAIL mid_reset_out got %b expected %b", got, ex);
    else passes++;
    checks++;
    if (bus16.stall_cnt_o !== 16'd0) $display("[TB] FAIL mid_reset_cnt got %0d expected 0", bus16.stall_cnt_o);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    drive({4'b0000, FENCE});
    expQ.push_back({5'b00000, 4'b0000, 2'b10});
    @(negedge clk);
    got = observe();
    ex  = expQ.pop_front();
    checks++;
    if (got !== ex) $display("[TB] FAIL mid_run got %b expected %b", got, ex);
    else passes++;
    @(posedge clk); #1;
    drive({4'b0100, REDIR});
    expQ.push_back({5'b00011, 4'b0010, 2'b00});
    @(negedge clk);
    got = observe();
    ex  = expQ.pop_front();
    checks++;
    if (got !== ex) $display("[TB] FAIL mid_pend got %b expected %b", got, ex);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive({4'b0000, IDLE});
    expQ.push_back(11'd0);
    @(negedge clk);
    got = observe();
    ex  = expQ.pop_front();
    checks++;
    if (got !== ex) $display("[TB] FAIL mid_pend_cleared got %b expected %b", got, ex);
    else passes++;
    checks++;
    if (bus16.flush_cnt_o !== 16'd0) $display("[TB] FAIL mid_flush_cnt got %0d expected 0", bus16.flush_cnt_o);
    else passes++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    drive({4'b0000, IDLE});
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] starting pipe_ctrl_gen checks");
    test_reset();
    test_arbitration();
    test_fence();
    test_wfi();
    test_redirect();
    test_counters();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
